// File: rtl/fft_r2_ctrl.sv
// Address/strobe sequencer for an in-place radix-2 DIF FFT.
// Drives dual-port sample RAM and twiddle ROM; write-back mirrors reads.
module fft_r2_ctrl #(
    parameter int N      = 16,
    parameter int LOG2N  = 4,
    parameter int RD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     rd_en,
    output logic [LOG2N-1:0]         rd_addr_a,
    output logic [LOG2N-1:0]         rd_addr_b,
    output logic [LOG2N-2:0]         tw_addr,
    output logic                     wr_en,
    output logic [LOG2N-1:0]         wr_addr_a,
    output logic [LOG2N-1:0]         wr_addr_b,
    output logic [$clog2(LOG2N):0]   stage
);

    localparam int AW   = LOG2N;
    localparam int KW   = LOG2N - 1;
    localparam int SW   = $clog2(LOG2N) + 1;
    localparam int HALF = N / 2;
    localparam int BW   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_BUBBLE,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [KW-1:0]   r_k;
    logic [SW-1:0]   r_stage;
    logic [BW-1:0]   r_bcnt;
    logic            r_busy;
    logic            r_done;
    logic            r_rd_en;
    logic [AW-1:0]   r_rd_a;
    logic [AW-1:0]   r_rd_b;
    logic [KW-1:0]   r_tw;

    logic            r_dly_en [RD_LAT];
    logic [AW-1:0]   r_dly_a  [RD_LAT];
    logic [AW-1:0]   r_dly_b  [RD_LAT];

    logic [KW-1:0]   w_k_nxt;
    logic [SW-1:0]   w_stage_nxt;
    logic [SW-1:0]   w_s;
    logic [KW-1:0]   w_k;
    logic [AW-1:0]   w_kk;
    logic [AW-1:0]   w_span;
    logic [AW-1:0]   w_j;
    logic [AW-1:0]   w_a;
    logic [AW-1:0]   w_b;
    logic [KW-1:0]   w_tw;

    assign w_k_nxt     = r_k + KW'(1);
    assign w_stage_nxt = r_stage + SW'(1);

    // Select the butterfly that will be presented in the next cycle.
    always_comb begin
        w_s = r_stage;
        w_k = w_k_nxt;
        if (r_state == S_IDLE) begin
            w_s = '0;
            w_k = '0;
        end else if (r_state == S_BUBBLE) begin
            w_s = w_stage_nxt;
            w_k = '0;
        end
    end

    // span is a power of two, so k mod span is a mask and k - j = g*span.
    always_comb begin
        w_kk   = {1'b0, w_k};
        w_span = AW'(HALF) >> w_s;
        w_j    = w_kk & (w_span - AW'(1));
        w_a    = ((w_kk - w_j) << 1) + w_j;
        w_b    = w_a + w_span;
        w_tw   = KW'(w_j << w_s);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_stage <= '0;
            r_bcnt  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rd_en <= 1'b0;
            r_rd_a  <= '0;
            r_rd_b  <= '0;
            r_tw    <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_dly_en[i] <= 1'b0;
                r_dly_a[i]  <= '0;
                r_dly_b[i]  <= '0;
            end
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_k     <= '0;
                        r_stage <= '0;
                        r_busy  <= 1'b1;
                        r_rd_en <= 1'b1;
                        r_rd_a  <= w_a;
                        r_rd_b  <= w_b;
                        r_tw    <= w_tw;
                    end
                end
                S_RUN: begin
                    if (r_k == KW'(HALF - 1)) begin
                        r_state <= S_BUBBLE;
                        r_rd_en <= 1'b0;
                        r_bcnt  <= BW'(RD_LAT - 1);
                    end else begin
                        r_k    <= w_k_nxt;
                        r_rd_a <= w_a;
                        r_rd_b <= w_b;
                        r_tw   <= w_tw;
                    end
                end
                S_BUBBLE: begin
                    if (r_bcnt != '0) begin
                        r_bcnt <= r_bcnt - BW'(1);
                    end else if (r_stage == SW'(LOG2N - 1)) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_RUN;
                        r_stage <= w_stage_nxt;
                        r_k     <= '0;
                        r_rd_en <= 1'b1;
                        r_rd_a  <= w_a;
                        r_rd_b  <= w_b;
                        r_tw    <= w_tw;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase

            r_dly_en[0] <= r_rd_en;
            r_dly_a[0]  <= r_rd_a;
            r_dly_b[0]  <= r_rd_b;
            for (int i = 1; i < RD_LAT; i++) begin
                r_dly_en[i] <= r_dly_en[i-1];
                r_dly_a[i]  <= r_dly_a[i-1];
                r_dly_b[i]  <= r_dly_b[i-1];
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign rd_en     = r_rd_en;
    assign rd_addr_a = r_rd_a;
    assign rd_addr_b = r_rd_b;
    assign tw_addr   = r_tw;
    assign stage     = r_stage;
    assign wr_en     = r_dly_en[RD_LAT-1];
    assign wr_addr_a = r_dly_a[RD_LAT-1];
    assign wr_addr_b = r_dly_b[RD_LAT-1];

endmodule

// File: tb/tb_fft_r2_ctrl.sv
// Scoreboard bench for fft_r2_ctrl with RD_LAT=1 and RD_LAT=2 instances.
// Expected outputs come from a cycle-offset model of the schedule.
module tb_fft_r2_ctrl;

    localparam int N = 16;
    localparam int L = 4;
    localparam int H = N / 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;

    always #5 clk = ~clk;

    logic       d0_busy, d0_done, d0_rd_en, d0_wr_en;
    logic [3:0] d0_a, d0_b, d0_wa, d0_wb;
    logic [2:0] d0_tw, d0_st;
    logic       d1_busy, d1_done, d1_rd_en, d1_wr_en;
    logic [3:0] d1_a, d1_b, d1_wa, d1_wb;
    logic [2:0] d1_tw, d1_st;

    fft_r2_ctrl #(.N(N), .LOG2N(L), .RD_LAT(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .busy(d0_busy), .done(d0_done), .rd_en(d0_rd_en),
        .rd_addr_a(d0_a), .rd_addr_b(d0_b), .tw_addr(d0_tw),
        .wr_en(d0_wr_en), .wr_addr_a(d0_wa), .wr_addr_b(d0_wb),
        .stage(d0_st)
    );

    fft_r2_ctrl #(.N(N), .LOG2N(L), .RD_LAT(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .busy(d1_busy), .done(d1_done), .rd_en(d1_rd_en),
        .rd_addr_a(d1_a), .rd_addr_b(d1_b), .tw_addr(d1_tw),
        .wr_en(d1_wr_en), .wr_addr_a(d1_wa), .wr_addr_b(d1_wb),
        .stage(d1_st)
    );

    typedef struct {
        bit busy, done, rd_en, wr_en, chk_all;
        int st, a, b, tw, wa, wb;
        int cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int errors = 0;
    int checks = 0;
    int e = 0;
    int t0[2];
    bit has[2];

    // Butterfly read issued in relative cycle d of a run, if any.
    function automatic void rd_model(input int rl, input int d, output bit en,
                                     output int st, output int a,
                                     output int b, output int tw);
        int per, p, span, g, j;
        per = H + rl;
        en = 0; st = 0; a = 0; b = 0; tw = 0;
        if (d >= 1 && d <= L * per) begin
            st = (d - 1) / per;
            p  = (d - 1) % per;
            if (p < H) begin
                en   = 1;
                span = N >> (st + 1);
                g    = p / span;
                j    = p % span;
                a    = 2 * span * g + j;
                b    = a + span;
                tw   = j << st;
            end
        end
    endfunction

    function automatic exp_t predict(input int i, input int rl);
        exp_t x;
        int d, tt, s2, t2;
        x = '{default: 0};
        x.cyc = e;
        x.chk_all = !has[i];
        if (has[i]) begin
            d  = e - t0[i] + 1;
            tt = L * (H + rl);
            x.busy = (d >= 1 && d <= tt);
            x.done = (d == tt + 1);
            rd_model(rl, d, x.rd_en, x.st, x.a, x.b, x.tw);
            rd_model(rl, d - rl, x.wr_en, s2, x.wa, x.wb, t2);
        end
        return x;
    endfunction

    task automatic model_edge(input bit s, input bit r);
        for (int i = 0; i < 2; i++) begin
            int rl;
            rl = i + 1;
            if (!r) begin
                has[i] = 0;
            end else if (s && (!has[i] || e - t0[i] >= L * (H + rl) + 2)) begin
                has[i] = 1;
                t0[i]  = e;
            end
            if (i == 0) q0.push_back(predict(0, rl));
            else        q1.push_back(predict(1, rl));
        end
        e++;
    endtask

    task automatic step(input bit s, input bit r);
        @(negedge clk);
        start = s;
        rst_n = r;
        model_edge(s, r);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cmp(input string tag, input exp_t x,
                       input bit busy, input bit done, input bit rde,
                       input bit wre, input int st, input int a,
                       input int b, input int tw, input int wa, input int wb);
        string p;
        p = $sformatf("%s edge%0d", tag, x.cyc);
        chk({p, " busy"}, busy, x.busy);
        chk({p, " done"}, done, x.done);
        chk({p, " rd_en"}, rde, x.rd_en);
        chk({p, " wr_en"}, wre, x.wr_en);
        if (x.rd_en || x.chk_all) begin
            chk({p, " stage"}, st, x.st);
            chk({p, " rd_addr_a"}, a, x.a);
            chk({p, " rd_addr_b"}, b, x.b);
            chk({p, " tw_addr"}, tw, x.tw);
        end
        if (x.wr_en || x.chk_all) begin
            chk({p, " wr_addr_a"}, wa, x.wa);
            chk({p, " wr_addr_b"}, wb, x.wb);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0)
                cmp("lat1", q0.pop_front(), d0_busy, d0_done, d0_rd_en,
                    d0_wr_en, d0_st, d0_a, d0_b, d0_tw, d0_wa, d0_wb);
            if (q1.size() > 0)
                cmp("lat2", q1.pop_front(), d1_busy, d1_done, d1_rd_en,
                    d1_wr_en, d1_st, d1_a, d1_b, d1_tw, d1_wa, d1_wb);
        end
    end

    initial begin
        has[0] = 0;
        has[1] = 0;
        t0[0] = 0;
        t0[1] = 0;

        repeat (2) step(0, 0);
        repeat (10) step(0, 1);

        // Single run with ignored start pulses at cycles 5, 20 and 37.
        step(1, 1);
        for (int c = 1; c <= 46; c++)
            step(c == 5 || c == 20 || c == 37, 1);

        // Reset in cycle 12, then a fresh full run.
        step(1, 1);
        for (int c = 1; c <= 12; c++)
            step(0, c != 12);
        repeat (3) step(0, 1);
        step(1, 1);
        repeat (45) step(0, 1);

        for (int c = 0; c < 500; c++)
            step($urandom_range(0, 9) == 0, $urandom_range(0, 79) != 0);

        repeat (45) step(0, 1);

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard drained", q0.size() + q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
